encode_8x3: RTL and testbench

ENCODE_8X3 -- requirements
Module: encode_8x3

---
 rtl/encode_pkg.sv | 14 +
 rtl/prio_enc8_core.sv | 31 +++
 rtl/encode_8x3.sv | 50 +++++
 tb/tb_encode_8x3.sv | 128 ++++++++++++
 4 files changed

// File: rtl/encode_pkg.sv
// Shared widths and result type for the 8-to-3 priority encoder.
// The core and the top both import this package.
package encode_pkg;

    localparam int IN_W  = 8;
    localparam int OUT_W = 3;

    typedef struct packed {
        logic [OUT_W-1:0] out;
        logic             valid;
        logic             multi;
    } enc_result_t;

endpackage

// File: rtl/prio_enc8_core.sv
// Combinational 8-to-3 priority encoder with one-hot violation (multi) detection.
// The selection direction is fixed at elaboration by PRIORITY_MSB.
module prio_enc8_core
    import encode_pkg::*;
#(
    parameter bit PRIORITY_MSB = 1'b1
) (
    input  logic [IN_W-1:0] in,
    output enc_result_t     res
);

    logic [3:0] set_cnt;

    // Ascending scan: for MSB priority every later hit overwrites the index,
    // for LSB priority only the first hit is kept.
    always_comb begin
        res     = '0;
        set_cnt = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (in[i]) begin
                set_cnt = set_cnt + 4'd1;
                if (PRIORITY_MSB || !res.valid) begin
                    res.out = i[OUT_W-1:0];
                end
                res.valid = 1'b1;
            end
        end
        res.multi = (set_cnt >= 4'd2);
    end

endmodule

// File: rtl/encode_8x3.sv
// 8-to-3 priority encoder top: combinational core plus an optional output register.
// There is no handshake: every sampled input yields a result, nothing is dropped.
module encode_8x3
    import encode_pkg::*;
#(
    parameter bit PRIORITY_MSB = 1'b1,
    parameter bit REG_OUT      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic             valid,
    output logic             multi
);

    enc_result_t core_res;
    enc_result_t out_res;

    prio_enc8_core #(
        .PRIORITY_MSB(PRIORITY_MSB)
    ) u_core (
        .in (in),
        .res(core_res)
    );

    generate
        if (REG_OUT) begin : g_reg
            enc_result_t res_q;

            // Reset wins over the sample on the same edge, dropping any pending result.
            always_ff @(posedge clk) begin
                if (rst) begin
                    res_q <= '0;
                end else begin
                    res_q <= core_res;
                end
            end

            assign out_res = res_q;
        end else begin : g_comb
            assign out_res = core_res;
        end
    endgenerate

    assign out   = out_res.out;
    assign valid = out_res.valid;
    assign multi = out_res.multi;

endmodule

// File: tb/tb_encode_8x3.sv
// Bench for encode_8x3: registered and combinational instances for both priority
// directions, compared against an arithmetic reference model.
module tb_encode_8x3;

    logic       clk;
    logic       rst;
    logic [7:0] in;

    logic [2:0] rm_out, rl_out, cm_out, cl_out;
    logic       rm_valid, rl_valid, cm_valid, cl_valid;
    logic       rm_multi, rl_multi, cm_multi, cl_multi;

    int errors = 0;
    int checks = 0;

    encode_8x3 #(.PRIORITY_MSB(1'b1), .REG_OUT(1'b1)) u_reg_msb (
        .clk(clk), .rst(rst), .in(in), .out(rm_out), .valid(rm_valid), .multi(rm_multi));
    encode_8x3 #(.PRIORITY_MSB(1'b0), .REG_OUT(1'b1)) u_reg_lsb (
        .clk(clk), .rst(rst), .in(in), .out(rl_out), .valid(rl_valid), .multi(rl_multi));
    encode_8x3 #(.PRIORITY_MSB(1'b1), .REG_OUT(1'b0)) u_comb_msb (
        .clk(clk), .rst(rst), .in(in), .out(cm_out), .valid(cm_valid), .multi(cm_multi));
    encode_8x3 #(.PRIORITY_MSB(1'b0), .REG_OUT(1'b0)) u_comb_lsb (
        .clk(clk), .rst(rst), .in(in), .out(cl_out), .valid(cl_valid), .multi(cl_multi));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {index, valid, multi}. Index is floor(log2) of the whole value
    // (MSB priority) or of its isolated lowest set bit (LSB priority).
    function automatic logic [4:0] model(input logic [7:0] v, input bit msb);
        int p;
        int idx;
        int n;
        idx = 0;
        n   = $countones(v);
        p   = msb ? int'(v) : int'(v) & -int'(v);
        while (p > 1) begin
            p = p >> 1;
            idx++;
        end
        return {idx[2:0], v != 8'd0, n >= 2};
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed={out,valid,multi}=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic check_reg(input string tag, input logic [4:0] exp_msb, input logic [4:0] exp_lsb);
        check({tag, "_reg_msb"}, {rm_out, rm_valid, rm_multi}, exp_msb);
        check({tag, "_reg_lsb"}, {rl_out, rl_valid, rl_multi}, exp_lsb);
    endtask

    // Apply v at the falling edge, check the combinational instances without any
    // clock edge, then check the registered ones just after the next rising edge.
    task automatic step(input string tag, input logic [7:0] v, input logic r);
        @(negedge clk);
        in  = v;
        rst = r;
        #1;
        check({tag, "_comb_msb"}, {cm_out, cm_valid, cm_multi}, model(v, 1'b1));
        check({tag, "_comb_lsb"}, {cl_out, cl_valid, cl_multi}, model(v, 1'b0));
        @(posedge clk);
        #1;
        if (r) check_reg(tag, 5'd0, 5'd0);
        else   check_reg(tag, model(v, 1'b1), model(v, 1'b0));
    endtask

    initial begin
        logic [7:0] v;
        in  = 8'h00;
        rst = 1'b1;

        // Reset for two cycles with garbage on the inputs.
        repeat (2) step("reset", 8'($urandom_range(0, 255)), 1'b1);

        // Walking one.
        for (int k = 0; k < 8; k++) begin
            v = 8'd1 << k;
            step("walk", v, 1'b0);
        end

        step("zero", 8'h00, 1'b0);
        step("prio", 8'b1001_0010, 1'b0);
        step("prio_lit_msb", 8'b1001_0010, 1'b0);
        check("prio_msb_idx7", {rm_out, rm_valid, rm_multi}, {3'd7, 1'b1, 1'b1});
        check("prio_lsb_idx1", {rl_out, rl_valid, rl_multi}, {3'd1, 1'b1, 1'b1});

        // Mid-stream reset then recovery on the held input.
        step("mid_rst", 8'b0010_0000, 1'b1);
        step("post_rst", 8'b0010_0000, 1'b0);
        check("post_rst_idx5", {rm_out, rm_valid}, {3'd5, 1'b1});

        // Combinational mode answers within the same timestep.
        @(negedge clk);
        in = 8'b0100_0000;
        #1;
        check("comb_idx6", {cm_out, cm_valid, cm_multi}, {3'd6, 1'b1, 1'b0});

        // Registered outputs stay put while the input glitches between edges.
        for (int g = 0; g < 4; g++) begin
            v = 8'($urandom_range(0, 255));
            step("glitch_base", v, 1'b0);
            repeat (3) begin
                in = 8'($urandom_range(0, 255));
                #2;
                check_reg("glitch_hold", model(v, 1'b1), model(v, 1'b0));
            end
        end

        // Exhaustive back-to-back sweep.
        for (int i = 0; i < 256; i++) begin
            step("sweep", 8'(i), 1'b0);
        end

        // Random stream with occasional resets.
        for (int i = 0; i < 200; i++) begin
            step("rand", 8'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
